// File: rtl/led_pkg.sv
// led_pkg: shared mode encodings and chase direction type
// for the LED pattern generator.
package led_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'b00,
      BLINK = 2'b01,
      CHASE = 2'b10,
      PWM   = 2'b11
   } mode_e;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: free-running DIV_W-bit counter, tick pulses
// for one clock while the count is all-ones.
// Ports: clk, rst (sync, active-high), tick (one-cycle pulse).
module led_prescaler #(
   parameter int DIV_W = 24
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt + ONE;
   end

   assign tick = &cnt;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: OFF/BLINK/CHASE/PWM LED driver, tick-paced.
// Ports: CLK, RST (sync high), MODE[1:0], DUTY[PWM_W-1:0],
//        LED[NUM_LEDS-1:0] (registered), TICK (prescaler wrap).
// Option: define LED_BREATHE_EN for a tick-paced duty ramp
//         that replaces DUTY in PWM mode.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int NUM_LEDS = 4,
   parameter int DIV_W    = 24,
   parameter int PWM_W    = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [1:0]          MODE,
   input  logic [PWM_W-1:0]    DUTY,
   output logic [NUM_LEDS-1:0] LED,
   output logic                TICK
);

   localparam logic [NUM_LEDS-1:0] POS0 = NUM_LEDS'(1);
   localparam logic [PWM_W-1:0]    P1   = PWM_W'(1);

   logic                tick;
   mode_e               mode_in;
   mode_e               mode_q;
   logic                chg;
   logic                phase_q, phase_d;
   logic [NUM_LEDS-1:0] pos_q, pos_d;
   dir_e                dir_q, dir_d;
   logic [PWM_W-1:0]    pcnt_q, pcnt_d;
   logic [PWM_W-1:0]    duty;
   logic [NUM_LEDS-1:0] led_d;

   led_prescaler #(
      .DIV_W (DIV_W)
   ) u_pre (
      .clk  (CLK),
      .rst  (RST),
      .tick (tick)
   );

   assign TICK    = tick;
   assign mode_in = mode_e'(MODE);
   // Any mode change restarts all pattern state; a tick
   // landing on that same edge is lost with it.
   assign chg     = (mode_in != mode_q);

`ifdef LED_BREATHE_EN
   logic [PWM_W-1:0] ramp_q, ramp_d;
   dir_e             rdir_q, rdir_d;

   assign duty = ramp_q;

   always_comb begin
      ramp_d = ramp_q;
      rdir_d = rdir_q;
      if (chg) begin
         ramp_d = '0;
         rdir_d = UP;
      end else if (mode_q == PWM && tick) begin
         if (rdir_q == UP) begin
            ramp_d = ramp_q + P1;
            if (ramp_d == '1) rdir_d = DOWN;
         end else begin
            ramp_d = ramp_q - P1;
            if (ramp_d == '0) rdir_d = UP;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ramp_q <= '0;
         rdir_q <= UP;
      end else begin
         ramp_q <= ramp_d;
         rdir_q <= rdir_d;
      end
   end
`else
   assign duty = DUTY;
`endif

   always_comb begin
      phase_d = phase_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      pcnt_d  = pcnt_q;
      led_d   = '0;

      unique case (1'b1)
         (mode_q == BLINK): led_d = {NUM_LEDS{phase_q}};
         (mode_q == CHASE): led_d = pos_q;
         (mode_q == PWM):   led_d = {NUM_LEDS{pcnt_q < duty}};
         default:           led_d = '0;
      endcase

      if (chg) begin
         phase_d = 1'b0;
         pos_d   = POS0;
         dir_d   = UP;
         pcnt_d  = '0;
      end else begin
         unique case (1'b1)
            (mode_q == BLINK): begin
               if (tick) phase_d = ~phase_q;
            end
            (mode_q == CHASE): begin
               // A single LED has nowhere to move.
               if (tick && NUM_LEDS > 1) begin
                  if (dir_q == UP) begin
                     pos_d = pos_q << 1;
                     if (pos_d[NUM_LEDS-1]) dir_d = DOWN;
                  end else begin
                     pos_d = pos_q >> 1;
                     if (pos_d[0]) dir_d = UP;
                  end
               end
            end
            (mode_q == PWM): pcnt_d = pcnt_q + P1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_q  <= OFF;
         phase_q <= 1'b0;
         pos_q   <= POS0;
         dir_q   <= UP;
         pcnt_q  <= '0;
         LED     <= '0;
      end else begin
         mode_q  <= mode_in;
         phase_q <= phase_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         pcnt_q  <= pcnt_d;
         LED     <= led_d;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed literal checks plus a random run
// compared every cycle against a count-based pattern model.
module tb_led_pattern_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode = 2'b00;
   logic [3:0] duty = 4'd0;
   logic [3:0] led;
   logic       tick;
   logic [0:0] led1;
   logic       tick1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_pattern_gen #(
      .NUM_LEDS (4),
      .DIV_W    (4),
      .PWM_W    (4)
   ) dut (
      .CLK  (clk),
      .RST  (rst),
      .MODE (mode),
      .DUTY (duty),
      .LED  (led),
      .TICK (tick)
   );

   led_pattern_gen #(
      .NUM_LEDS (1),
      .DIV_W    (4),
      .PWM_W    (4)
   ) dut1 (
      .CLK  (clk),
      .RST  (rst),
      .MODE (mode),
      .DUTY (duty),
      .LED  (led1),
      .TICK (tick1)
   );

   // Model: pattern as a function of ticks and cycles since
   // the current mode was entered.
   function automatic int tri_v(int tk);
      int t;
      t = tk % 30;
      return (t <= 15) ? t : 30 - t;
   endfunction

   function automatic logic [31:0] pat(int n, int md, int tk,
                                       int k, int d);
      logic [31:0] ones;
      int p, per, t, dd;
      ones = (n == 32) ? 32'hffff_ffff : ((32'h1 << n) - 1);
      case (md)
         1: return (tk % 2 == 1) ? ones : 32'h0;
         2: begin
            if (n == 1) p = 0;
            else begin
               per = 2 * (n - 1);
               t   = tk % per;
               p   = (t < n) ? t : per - t;
            end
            return 32'h1 << p;
         end
         3: begin
`ifdef LED_BREATHE_EN
            dd = tri_v(tk);
`else
            dd = d;
`endif
            return ((k % 16) < dd) ? ones : 32'h0;
         end
         default: return 32'h0;
      endcase
   endfunction

   int          m_mode = 0;
   int          m_tk = 0;
   int          m_k = 0;
   int          m_since = 0;
   bit          m_valid = 1'b0;
   bit          m_tnow;
   logic [31:0] v4, v1;
   logic [3:0]  e_led = '0;
   logic        e_led1 = 1'b0;
   logic        e_tick = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_since = 0;
         m_mode  = 0;
         m_tk    = 0;
         m_k     = 0;
         e_led   = '0;
         e_led1  = 1'b0;
         m_valid = 1'b1;
      end else begin
         m_tnow = (m_since % 16 == 15);
         v4 = pat(4, m_mode, m_tk, m_k, int'(duty));
         v1 = pat(1, m_mode, m_tk, m_k, int'(duty));
         e_led  = v4[3:0];
         e_led1 = v1[0];
         if (int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_tk   = 0;
            m_k    = 0;
         end else begin
            if (m_tnow) m_tk++;
            m_k++;
         end
         m_since++;
      end
      e_tick = (m_since % 16 == 15);
   end

   always @(negedge clk) begin
      if (m_valid) begin
         checks++;
         if (led !== e_led) begin
            errors++;
            $display("FAIL model_led t=%0t got %b expected %b",
                     $time, led, e_led);
         end
         checks++;
         if (tick !== e_tick) begin
            errors++;
            $display("FAIL model_tick t=%0t got %b expected %b",
                     $time, tick, e_tick);
         end
         checks++;
         if (led1 !== e_led1) begin
            errors++;
            $display("FAIL model_led1 t=%0t got %b expected %b",
                     $time, led1, e_led1);
         end
      end
   end

   task automatic chk(string name, logic [31:0] got,
                      logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0h expected %0h",
                  name, $time, got, exp);
      end
   endtask

   task automatic wait_tick();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick && n < 40);
      checks++;
      if (!tick) begin
         errors++;
         $display("FAIL tick_timeout t=%0t got no tick expected one",
                  $time);
      end
   endtask

   task automatic count_hi(int len, output int hi);
      hi = 0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (led == 4'hF) hi++;
      end
   endtask

   logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                           4'b0100, 4'b0010, 4'b0001, 4'b0010};

   initial begin
      int n, hi;

      rst  = 1'b1;
      mode = 2'b10;
      repeat (3) @(negedge clk);
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
      rst = 1'b0;
      n = 0;
      while (!tick && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("first_tick_latency", n, 15);

      @(negedge clk);
      chk("chase_0", 32'(led), 32'(seq[0]));
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk("chase_seq", 32'(led), 32'(seq[i]));
         chk("chase_n1", 32'(led1), 32'h1);
         if (i < 7) begin
            wait_tick();
            @(negedge clk);
         end
      end

      wait_tick();
      repeat (2) @(negedge clk);
      chk("chase_0100", 32'(led), 32'h4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_led", 32'(led), 32'h0);
      chk("rst_mid_tick", 32'(tick), 32'h0);
      wait_tick();
      @(negedge clk);
      chk("restart_pos", 32'(led), 32'h1);
      @(negedge clk);
      chk("restart_up", 32'(led), 32'h2);

      mode = 2'b01;
      wait_tick();
      @(negedge clk);
      chk("blink_start", 32'(led), 32'h0);
      @(negedge clk);
      chk("blink_on", 32'(led), 32'hF);
      wait_tick();
      @(negedge clk);
      chk("blink_hold", 32'(led), 32'hF);
      @(negedge clk);
      chk("blink_off", 32'(led), 32'h0);

      mode = 2'b11;
`ifdef LED_BREATHE_EN
      duty = 4'd0;
      wait_tick();
      @(negedge clk);
      for (int w = 1; w <= 31; w++) begin
         count_hi(16, hi);
         chk("breathe_window", hi, tri_v(w));
      end
`else
      duty = 4'd0;
      repeat (2) @(negedge clk);
      count_hi(64, hi);
      chk("pwm_duty0", hi, 0);
      duty = 4'd5;
      repeat (2) @(negedge clk);
      count_hi(16, hi);
      chk("pwm_duty5", hi, 5);
      count_hi(16, hi);
      chk("pwm_duty5_again", hi, 5);
      duty = 4'd15;
      repeat (2) @(negedge clk);
      count_hi(16, hi);
      chk("pwm_duty15", hi, 15);
`endif

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 119) == 0)
            mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 2))
               0:       duty = 4'd0;
               1:       duty = 4'd15;
               default: duty = 4'($urandom_range(0, 15));
            endcase
         end
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 4, giving the number of LED output channels (1..32).
REQ-002 The block SHALL have parameter DIV_W, default 24, giving the prescaler width; the tick period is 2^DIV_W clocks.
REQ-003 The block SHALL have parameter PWM_W, default 8, giving the PWM counter and duty width.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port MODE, input, 2 bits: 00 OFF, 01 BLINK, 10 CHASE, 11 PWM.
REQ-007 The block SHALL have port DUTY, input, PWM_W bits: the PWM on-threshold.
REQ-008 The block SHALL have port LED, output, NUM_LEDS bits: registered LED drive, 1 = lit.
REQ-009 The block SHALL have port TICK, output, 1 bit: a one-cycle pulse at each prescaler wrap.

Function
REQ-010 Prescaler SHALL count up by 1 per clock, wrapping from all-ones to 0; TICK SHALL be 1 exactly in the cycle the count equals all-ones.
REQ-011 MODE SHALL be sampled into a mode register each clock; a change of MODE SHALL clear blink phase, chase position/direction and PWM counter in the following cycle. The prescaler SHALL NOT be cleared.
REQ-012 OFF: LED SHALL be all zeros one cycle after the mode register holds OFF.
REQ-013 BLINK: a phase bit SHALL toggle on each TICK; all LED bits SHALL equal the phase bit, starting at 0 after entry.
REQ-014 CHASE: a one-hot position SHALL start at bit 0 with direction UP; on each TICK it SHALL shift one place in the current direction.
REQ-015 CHASE state machine: UP->DOWN when the shift lands on bit NUM_LEDS-1; DOWN->UP when the shift lands on bit 0; with NUM_LEDS=1 the position SHALL stay at bit 0.
REQ-016 PWM: a PWM_W-bit counter SHALL increment every clock and wrap; all LED bits SHALL be 1 when counter < duty, else 0 (unsigned compare).
REQ-017 Duty boundaries: duty 0 SHALL give LED constantly 0; duty all-ones SHALL give LED 1 for 2^PWM_W-1 of every 2^PWM_W cycles.
REQ-018 LED SHALL be registered; it SHALL reflect internal state with one cycle of latency.
REQ-019 A TICK coincident with a MODE change SHALL be ignored by the newly selected mode.

Reset
REQ-020 While RST is high at a clock edge, prescaler, PWM counter, blink phase SHALL become 0; chase position SHALL become bit 0 with direction UP; mode register SHALL become OFF.
REQ-021 LED and TICK SHALL be 0 in the cycle after any reset edge; reset mid-sequence SHALL discard all progress.
REQ-022 After RST is released, the prescaler SHALL first reach all-ones 2^DIV_W-1 clocks later.

Configuration
REQ-023 With macro LED_BREATHE_EN defined, PWM mode SHALL ignore DUTY and use an internal duty ramp: starts at 0, +1 per TICK up to all-ones, then -1 per TICK down to 0, repeating; the ramp SHALL be reset by RST and on entry to PWM.
REQ-024 Without LED_BREATHE_EN, the ramp logic SHALL be absent and PWM mode SHALL use DUTY directly.

Structure
REQ-025 Mode encodings (OFF, BLINK, CHASE, PWM) and the chase direction type (UP, DOWN) SHALL be defined in shared package led_pkg.
REQ-026 The prescaler and TICK generation SHALL be a sub-module named led_prescaler, parametrised by DIV_W.

Verification (DIV_W=4, PWM_W=4, NUM_LEDS=4 unless stated)
REQ-027 RST high 3 cycles with MODE=10 -> LED=0000, TICK=0; first TICK 15 cycles after RST falls.
REQ-028 MODE=01 -> LED toggles 0000/1111 on every TICK, i.e. every 16 cycles.
REQ-029 MODE=10 -> LED sequence 0001,0010,0100,1000,0100,0010,0001,0010 on successive TICKs; NUM_LEDS=1 -> LED stays 1.
REQ-030 MODE=11, DUTY=0 -> LED 0 for 64 cycles; DUTY=5 -> LED high exactly 5 of every 16 cycles; DUTY=15 -> high 15 of 16.
REQ-031 Chase to position 0100, then assert RST 1 cycle -> LED=0000, next CHASE entry restarts at 0001 direction UP.
REQ-032 With LED_BREATHE_EN, MODE=11, DUTY=0 -> high count per 16-cycle PWM window rises 0,1,..,15 then falls 14,..,0 across TICKs.
